// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit for a shared-memory datapath (PC, IR, A/B, ALUOut, Data).
// A Moore FSM sequences fetch / decode / execute / writeback, stalls memory states on
// mem_ready, decodes ALU operations combinationally, supports BEQ/BNE and JAL, and traps
// on unsupported opcodes until reset.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   instr[31:0]         instruction register contents
//   zero                ALU zero flag
//   mem_ready           memory completes the current request this cycle
//   mem_req, mem_write  memory request and store strobe
//   adr_src             memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write  IR/OldPC load, PC load
//   reg_write           register file write enable
//   result_src[1:0]     result bus select (00 ALUOut, 01 Data, 10 ALU result)
//   alu_src_a[1:0]      ALU A select (00 PC, 01 OldPC, 10 rs1)
//   alu_src_b[1:0]      ALU B select (00 rs2, 01 imm, 10 const 4)
//   imm_src[2:0]        immediate format (000 I, 001 S, 010 B, 011 J)
//   alu_ctrl            ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   illegal             high while trapped
//   state_o[3:0]        current state encoding
module multicycle_control #(
    parameter int unsigned ALUCTRL_W   = 3,
    parameter int unsigned MEM_WAIT_EN = 1,
    parameter int unsigned SUPPORT_BNE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           imm_src,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 illegal,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBranch   = 4'd10,
        StTrap     = 4'd11
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    state_e     state_q, state_d;
    logic       ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] funct_code;
    logic [2:0] alu_code;
    logic       branch_ok;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // With waiting disabled every memory access completes in one cycle.
    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    assign branch_ok = (funct3 == 3'b000) || ((funct3 == 3'b001) && (SUPPORT_BNE != 0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Shared by EXECR and EXECI; instr[5] separates R-type sub from addi with imm[10] set.
    always_comb begin
        funct_code = AluAdd;
        case (funct3)
            3'b000:  funct_code = (instr[30] & instr[5]) ? AluSub : AluAdd;
            3'b010:  funct_code = AluSlt;
            3'b110:  funct_code = AluOr;
            3'b111:  funct_code = AluAnd;
            default: funct_code = AluAdd;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_code   = AluAdd;
        illegal    = 1'b0;
        state_o    = state_q;

        case (opcode)
            OpStore:  imm_src = 3'b001;
            OpBranch: imm_src = 3'b010;
            OpJal:    imm_src = 3'b011;
            default:  imm_src = 3'b000;
        endcase

        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) state_d = StDecode;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = branch_ok ? StBranch : StTrap;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (ready) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_code  = funct_code;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_code  = funct_code;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_d    = StAluWb;
            end
            StBranch: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_code   = AluSub;
                result_src = 2'b00;
                pc_write   = zero ^ funct3[0];
                state_d    = StFetch;
            end
            StTrap: begin
                illegal = 1'b1;
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase

        alu_ctrl      = '0;
        alu_ctrl[2:0] = alu_code;

        // Reset suppresses every strobe in the cycle it is sampled.
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            imm_src    = 3'b000;
            alu_ctrl   = '0;
            illegal    = 1'b0;
            state_o    = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  imm_src, alu_ctrl;
    logic [3:0]  state_o;

    // Second instance with BNE disabled; only its state and trap flag are checked.
    logic        n_mem_req, n_mem_write, n_adr_src, n_ir_write, n_pc_write, n_reg_write;
    logic        n_illegal;
    logic [1:0]  n_result_src, n_alu_src_a, n_alu_src_b;
    logic [2:0]  n_imm_src, n_alu_ctrl;
    logic [3:0]  n_state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control u_dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_ctrl(alu_ctrl), .illegal(illegal), .state_o(state_o)
    );

    multicycle_control #(.SUPPORT_BNE(0)) u_dut_nobne (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(n_mem_req), .mem_write(n_mem_write), .adr_src(n_adr_src),
        .ir_write(n_ir_write), .pc_write(n_pc_write), .reg_write(n_reg_write),
        .result_src(n_result_src), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
        .imm_src(n_imm_src), .alu_ctrl(n_alu_ctrl), .illegal(n_illegal), .state_o(n_state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        instr     = 32'h0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("rst_state", 32'(state_o), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_pc_write", 32'(pc_write), 0);
        tick();

        // lw x1,0(x2)
        rst   = 1'b0;
        instr = 32'h00012083;
        #1;
        check("lw_fetch_state", 32'(state_o), 0);
        check("lw_fetch_req", 32'(mem_req), 1);
        check("lw_fetch_irw", 32'(ir_write), 1);
        check("lw_fetch_pcw", 32'(pc_write), 1);
        check("lw_fetch_srcb", 32'(alu_src_b), 2);
        check("lw_fetch_res", 32'(result_src), 2);
        tick();
        check("lw_dec_state", 32'(state_o), 1);
        check("lw_dec_srca", 32'(alu_src_a), 1);
        check("lw_dec_srcb", 32'(alu_src_b), 1);
        check("lw_dec_regw", 32'(reg_write), 0);
        tick();
        check("lw_adr_state", 32'(state_o), 2);
        check("lw_adr_srca", 32'(alu_src_a), 2);
        tick();
        check("lw_rd_state", 32'(state_o), 3);
        check("lw_rd_adr", 32'(adr_src), 1);
        check("lw_rd_regw", 32'(reg_write), 0);
        tick();
        check("lw_wb_state", 32'(state_o), 4);
        check("lw_wb_regw", 32'(reg_write), 1);
        check("lw_wb_res", 32'(result_src), 1);
        tick();
        check("lw_done_state", 32'(state_o), 0);

        // sub x3,x1,x2
        instr = 32'h402081B3;
        tick();
        tick();
        check("sub_exec_state", 32'(state_o), 6);
        check("sub_alu", 32'(alu_ctrl), 1);
        check("sub_srcb", 32'(alu_src_b), 0);
        tick();
        check("sub_wb_state", 32'(state_o), 8);
        check("sub_wb_regw", 32'(reg_write), 1);
        check("sub_wb_res", 32'(result_src), 0);
        tick();

        // addi x1,x2,0x400 (instr[30]=1 must still add)
        instr = 32'h40010093;
        tick();
        tick();
        check("addi_state", 32'(state_o), 7);
        check("addi_alu", 32'(alu_ctrl), 0);
        check("addi_srcb", 32'(alu_src_b), 1);
        tick();
        tick();
        check("addi_done", 32'(state_o), 0);

        // beq taken
        instr = 32'h00208063;
        zero  = 1'b1;
        tick();
        check("beq_imm", 32'(imm_src), 2);
        tick();
        check("beq_state", 32'(state_o), 10);
        check("beq_alu", 32'(alu_ctrl), 1);
        check("beq_pcw", 32'(pc_write), 1);
        tick();
        check("beq_done", 32'(state_o), 0);

        // bne with zero=1: not taken; BNE-less instance traps
        instr = 32'h00209063;
        tick();
        tick();
        check("bne_state", 32'(state_o), 10);
        check("bne_pcw", 32'(pc_write), 0);
        check("nobne_state", 32'(n_state_o), 11);
        check("nobne_illegal", 32'(n_illegal), 1);
        zero = 1'b0;
        tick();
        check("bne_done", 32'(state_o), 0);

        // sw with three wait cycles in MEMWRITE
        instr = 32'h0020A023;
        tick();
        check("sw_imm", 32'(imm_src), 1);
        tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", 32'(state_o), 5);
            check("sw_wait_write", 32'(mem_write), 1);
            check("sw_wait_req", 32'(mem_req), 1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("sw_last_state", 32'(state_o), 5);
        check("sw_last_write", 32'(mem_write), 1);
        tick();
        check("sw_done", 32'(state_o), 0);

        // FETCH stall holds PC/IR
        mem_ready = 1'b0;
        instr     = 32'h000000EF;
        #1;
        check("fetch_stall_irw", 32'(ir_write), 0);
        tick();
        check("fetch_stall_state", 32'(state_o), 0);
        mem_ready = 1'b1;

        // jal x1,0
        tick();
        check("jal_dec", 32'(state_o), 1);
        tick();
        check("jal_state", 32'(state_o), 9);
        check("jal_pcw", 32'(pc_write), 1);
        check("jal_srca", 32'(alu_src_a), 1);
        check("jal_srcb", 32'(alu_src_b), 2);
        check("jal_imm", 32'(imm_src), 3);
        tick();
        check("jal_wb", 32'(state_o), 8);
        check("jal_wb_pcw", 32'(pc_write), 0);
        check("jal_wb_regw", 32'(reg_write), 1);
        tick();

        // Reset during MEMREAD
        instr = 32'h00012083;
        tick();
        tick();
        tick();
        check("rstmid_pre", 32'(state_o), 3);
        rst = 1'b1;
        #1;
        check("rstmid_regw", 32'(reg_write), 0);
        check("rstmid_req", 32'(mem_req), 0);
        check("rstmid_state", 32'(state_o), 0);
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_after_state", 32'(state_o), 0);
        check("rstmid_after_regw", 32'(reg_write), 0);
        tick();
        check("rstmid_dec", 32'(state_o), 1);
        instr = 32'h0000007F;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("trap_state", 32'(state_o), 11);
            check("trap_illegal", 32'(illegal), 1);
            check("trap_pcw", 32'(pc_write), 0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("trap_rst_state", 32'(state_o), 0);
        check("trap_rst_illegal", 32'(illegal), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
